sid_env_mux: RTL

Time-multiplexed ADSR envelope engine for the SID core, generalised to `NUM_VOICES` voices. It owns the per-voice envelope registers (attack/decay, sustain/release, gate) and services one voice per clock in round-robin. It emits a registered 8-bit envelope level tagged with its voice index, which the waveform/mixer path multiplies into the voice output. New behaviour over the current 2-voice engine:
- voice count is a parameter;
- full decay-to-sustain;
- SID-style piecewise exponential decay and release;
- re-trigger from the current level.

---
 rtl/sid_pkg.sv | 57 +++++
 rtl/sid_env_step.sv | 83 ++++++++
 rtl/sid_env_mux.sv | 99 +++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared types, register map and rate/exponent tables for the SID envelope engine
package sid_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ATTACK  = 2'd1,
      ST_DECAY   = 2'd2,
      ST_RELEASE = 2'd3
   } env_st_e;

   localparam logic [2:0] REG_ATK = 3'd4;
   localparam logic [2:0] REG_SUS = 3'd5;
   localparam logic [2:0] REG_WAV = 3'd6;

   typedef struct packed {
      env_st_e     st;
      logic [7:0]  env;
      logic [15:0] rate_cnt;
      logic [4:0]  exp_cnt;
      logic        gate_q;
   } voice_t;

   // Period in service visits between rate ticks.
   function automatic logic [15:0] rate_period(input logic [3:0] rate);
      logic [15:0] p;
      case (rate)
         4'd0:    p = 16'd9;
         4'd1:    p = 16'd32;
         4'd2:    p = 16'd63;
         4'd3:    p = 16'd95;
         4'd4:    p = 16'd149;
         4'd5:    p = 16'd220;
         4'd6:    p = 16'd267;
         4'd7:    p = 16'd313;
         4'd8:    p = 16'd392;
         4'd9:    p = 16'd977;
         4'd10:   p = 16'd1954;
         4'd11:   p = 16'd3126;
         4'd12:   p = 16'd3907;
         4'd13:   p = 16'd11720;
         4'd14:   p = 16'd19532;
         default: p = 16'd31251;
      endcase
      return p;
   endfunction

   // Rate ticks per one-step fall; approximates an exponential curve.
   function automatic logic [4:0] expdiv(input logic [7:0] lvl);
      if (lvl >= 8'h5D)      return 5'd1;
      else if (lvl >= 8'h36) return 5'd2;
      else if (lvl >= 8'h1A) return 5'd4;
      else if (lvl >= 8'h0E) return 5'd8;
      else if (lvl >= 8'h06) return 5'd16;
      else                   return 5'd30;
   endfunction

endpackage

// File: rtl/sid_env_step.sv
// rtl/sid_env_step.sv - combinational next-state for one envelope voice
module sid_env_step
   import sid_pkg::*;
(
   input  voice_t     cur,
   input  logic       gate,
   input  logic [7:0] atk,
   input  logic [7:0] sus,
   output voice_t     nxt
);

   logic [3:0]  rate;
   logic [15:0] cnt_inc;
   logic        tick;
   logic [4:0]  exp_inc;
   logic        exp_hit;
   logic [7:0]  sus_lvl;

   always_comb begin
      sus_lvl = {sus[3:0], sus[3:0]};
      case (cur.st)
         ST_ATTACK: rate = atk[3:0];
         ST_DECAY:  rate = atk[7:4];
         default:   rate = sus[7:4];
      endcase
      // >= keeps a lowered period from letting the counter run past it
      cnt_inc = cur.rate_cnt + 16'd1;
      tick    = (cnt_inc >= rate_period(rate));
      exp_inc = cur.exp_cnt + 5'd1;
      exp_hit = (exp_inc >= expdiv(cur.env));
   end

   always_comb begin
      nxt        = cur;
      nxt.gate_q = gate;
      if (gate && !cur.gate_q) begin
         nxt.st       = ST_ATTACK;
         nxt.rate_cnt = '0;
         nxt.exp_cnt  = '0;
      end else if (!gate && cur.gate_q) begin
         nxt.st       = ST_RELEASE;
         nxt.rate_cnt = '0;
         nxt.exp_cnt  = '0;
      end else if (cur.st != ST_IDLE) begin
         nxt.rate_cnt = tick ? 16'd0 : cnt_inc;
         case (cur.st)
            ST_ATTACK: begin
               if (cur.env == 8'hFF) begin
                  nxt.st = ST_DECAY;
               end else if (tick) begin
                  nxt.env = cur.env + 8'd1;
                  if (cur.env == 8'hFE) nxt.st = ST_DECAY;
               end
            end
            ST_DECAY: begin
               if (tick && (cur.env > sus_lvl)) begin
                  if (exp_hit) begin
                     nxt.env     = cur.env - 8'd1;
                     nxt.exp_cnt = '0;
                  end else begin
                     nxt.exp_cnt = exp_inc;
                  end
               end
            end
            ST_RELEASE: begin
               if (cur.env == 8'h00) begin
                  nxt.st = ST_IDLE;
               end else if (tick) begin
                  if (exp_hit) begin
                     nxt.env     = cur.env - 8'd1;
                     nxt.exp_cnt = '0;
                     if (cur.env == 8'h01) nxt.st = ST_IDLE;
                  end else begin
                     nxt.exp_cnt = exp_inc;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sid_env_mux.sv
// rtl/sid_env_mux.sv - round-robin time-multiplexed ADSR envelope engine
module sid_env_mux
   import sid_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int VW         = $clog2(NUM_VOICES)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          wr_en,
   input  logic [VW-1:0] wr_voice,
   input  logic [2:0]    wr_addr,
   input  logic [7:0]    wr_data,
   output logic          env_valid,
   output logic [VW-1:0] env_voice,
   output logic [7:0]    env_level
);

   voice_t        voice_q [NUM_VOICES];
   voice_t        voice_d [NUM_VOICES];
   logic [7:0]    atk_q   [NUM_VOICES];
   logic [7:0]    atk_d   [NUM_VOICES];
   logic [7:0]    sus_q   [NUM_VOICES];
   logic [7:0]    sus_d   [NUM_VOICES];
   logic          gate_q  [NUM_VOICES];
   logic          gate_d  [NUM_VOICES];
   logic [VW-1:0] slot_q, slot_d;
   logic          valid_q, valid_d;
   logic [VW-1:0] out_voice_q, out_voice_d;
   logic [7:0]    level_q, level_d;
   voice_t        cur, nxt;

   assign cur = voice_q[slot_q];

   sid_env_step u_step (
      .cur  (cur),
      .gate (gate_q[slot_q]),
      .atk  (atk_q[slot_q]),
      .sus  (sus_q[slot_q]),
      .nxt  (nxt)
   );

   always_comb begin
      voice_d     = voice_q;
      atk_d       = atk_q;
      sus_d       = sus_q;
      gate_d      = gate_q;
      slot_d      = slot_q;
      valid_d     = 1'b0;
      out_voice_d = out_voice_q;
      level_d     = level_q;
      if (ena) begin
         voice_d[slot_q] = nxt;
         slot_d          = slot_q + VW'(1);
         valid_d         = 1'b1;
         out_voice_d     = slot_q;
         level_d         = cur.env;
      end
      // Register writes land at the edge, so a same-cycle service sees the old value.
      if (wr_en) begin
         case (wr_addr)
            REG_ATK: atk_d[wr_voice]  = wr_data;
            REG_SUS: sus_d[wr_voice]  = wr_data;
            REG_WAV: gate_d[wr_voice] = wr_data[0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            voice_q[i] <= '0;
            atk_q[i]   <= '0;
            sus_q[i]   <= '0;
            gate_q[i]  <= 1'b0;
         end
         slot_q      <= '0;
         valid_q     <= 1'b0;
         out_voice_q <= '0;
         level_q     <= '0;
      end else begin
         voice_q     <= voice_d;
         atk_q       <= atk_d;
         sus_q       <= sus_d;
         gate_q      <= gate_d;
         slot_q      <= slot_d;
         valid_q     <= valid_d;
         out_voice_q <= out_voice_d;
         level_q     <= level_d;
      end
   end

   assign env_valid = valid_q;
   assign env_voice = out_voice_q;
   assign env_level = level_q;

endmodule
